// File: rtl/io_bus_responder.sv
// rtl/io_bus_responder.sv - memory-mapped IO responder: LED, input channel, output channel, cycle counter; optional input FIFO via IO_IN_FIFO_EN
module io_bus_responder #(
   parameter int LED_W      = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [7:0]       io_addr,
   input  logic [31:0]      io_dout,
   input  logic             io_we,
   input  logic             io_rd,
   output logic [31:0]      io_din,
   output logic [LED_W-1:0] led,
   input  logic [31:0]      in_data,
   input  logic             in_valid,
   output logic [31:0]      out_data,
   output logic             out_valid,
   input  logic             out_ack
);

   localparam logic [5:0] A_LED        = 6'h00;
   localparam logic [5:0] A_IN_STATUS  = 6'h01;
   localparam logic [5:0] A_IN_DATA    = 6'h02;
   localparam logic [5:0] A_OUT_STATUS = 6'h03;
   localparam logic [5:0] A_OUT_DATA   = 6'h04;
   localparam logic [5:0] A_CYCLE      = 6'h05;

   typedef enum logic {ST_IDLE, ST_BUSY} out_state_e;

   logic [5:0]       word;
   logic             unused_addr_lsbs;
   logic             wr_led, wr_in_status, rd_in_data, wr_out_data, wr_cycle;

   logic [LED_W-1:0] led_q;
   logic             overrun_q, overrun_d;
   logic [31:0]      cycle_q, cycle_d;
   out_state_e       state_q, state_d;
   logic [31:0]      out_data_q, out_data_d;

   logic             in_ready, pop, push, drop;
   logic [31:0]      in_head;
   logic [7:0]       in_count;

   assign word             = io_addr[7:2];
   assign unused_addr_lsbs = ^io_addr[1:0];
   assign wr_led           = io_we & (word == A_LED);
   assign wr_in_status     = io_we & (word == A_IN_STATUS);
   assign rd_in_data       = io_rd & (word == A_IN_DATA);
   assign wr_out_data      = io_we & (word == A_OUT_DATA);
   assign wr_cycle         = io_we & (word == A_CYCLE);

`ifdef IO_IN_FIFO_EN
   localparam int PTR_W = $clog2(FIFO_DEPTH);

   logic [31:0]      fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             full;

   assign full     = (count_q == (PTR_W+1)'(FIFO_DEPTH));
   assign in_ready = (count_q != '0);
   assign pop      = rd_in_data & in_ready;
   // a pop at the same edge frees the slot the push needs
   assign push     = in_valid & (~full | pop);
   assign drop     = in_valid & full & ~pop;
   assign in_head  = fifo_mem[rd_ptr_q];
   assign in_count = 8'(count_q);

   // FIFO pointer and occupancy next state
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // FIFO pointer and occupancy registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // FIFO storage, contents are meaningless while count is zero
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q] <= in_data;
   end
`else
   localparam int unused_fifo_depth = FIFO_DEPTH;

   logic        ready_q, ready_d;
   logic [31:0] hold_q, hold_d;

   assign in_ready = ready_q;
   assign pop      = rd_in_data & ready_q;
   // a read at the same edge empties the holding register for the new word
   assign push     = in_valid & (~ready_q | pop);
   assign drop     = in_valid & ready_q & ~pop;
   assign in_head  = hold_q;
   assign in_count = 8'd0;

   // holding register next state
   always_comb begin
      hold_d  = hold_q;
      ready_d = ready_q;
      if (push) begin
         hold_d  = in_data;
         ready_d = 1'b1;
      end else if (pop) begin
         ready_d = 1'b0;
      end
   end

   // holding register state
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         hold_q  <= '0;
         ready_q <= 1'b0;
      end else begin
         hold_q  <= hold_d;
         ready_q <= ready_d;
      end
   end
`endif

   // sticky overrun: a drop outranks a software clear at the same edge
   always_comb begin
      overrun_d = overrun_q;
      if (drop)                              overrun_d = 1'b1;
      else if (wr_in_status && io_dout[1])   overrun_d = 1'b0;
   end

   // free-running counter, a write forces zero at that edge
   always_comb begin
      cycle_d = cycle_q + 32'd1;
      if (wr_cycle) cycle_d = '0;
   end

   // output channel FSM: writes while busy are dropped, even alongside an ack
   always_comb begin
      state_d    = state_q;
      out_data_d = out_data_q;
      case (state_q)
         ST_IDLE: begin
            if (wr_out_data) begin
               out_data_d = io_dout;
               state_d    = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (out_ack) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // register file, counter and FSM state
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         led_q      <= '0;
         overrun_q  <= 1'b0;
         cycle_q    <= '0;
         state_q    <= ST_IDLE;
         out_data_q <= '0;
      end else begin
         if (wr_led) led_q <= io_dout[LED_W-1:0];
         overrun_q  <= overrun_d;
         cycle_q    <= cycle_d;
         state_q    <= state_d;
         out_data_q <= out_data_d;
      end
   end

   // zero-latency read mux, independent of io_rd
   always_comb begin
      io_din = '0;
      case (word)
         A_LED:        io_din = 32'(led_q);
         A_IN_STATUS:  io_din = {16'd0, in_count, 6'd0, overrun_q, in_ready};
         A_IN_DATA:    io_din = in_ready ? in_head : 32'd0;
         A_OUT_STATUS: io_din = {31'd0, (state_q == ST_BUSY)};
         A_CYCLE:      io_din = cycle_q;
         default:      io_din = '0;
      endcase
   end

   assign led       = led_q;
   assign out_data  = out_data_q;
   assign out_valid = (state_q == ST_BUSY);

endmodule

// File: tb/tb_io_bus_responder.sv
// tb/tb_io_bus_responder.sv - directed self-checking bench for io_bus_responder
module tb_io_bus_responder;

   logic        clk = 1'b0;
   logic        rstn;
   logic [7:0]  io_addr;
   logic [31:0] io_dout;
   logic        io_we;
   logic        io_rd;
   logic [31:0] io_din;
   logic [15:0] led;
   logic [31:0] in_data;
   logic        in_valid;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ack;

   int n_checks = 0;
   int n_fail   = 0;

   io_bus_responder #(.LED_W(16), .FIFO_DEPTH(4)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .io_addr   (io_addr),
      .io_dout   (io_dout),
      .io_we     (io_we),
      .io_rd     (io_rd),
      .io_din    (io_din),
      .led       (led),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ack   (out_ack)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
      @(negedge clk);
      io_addr = a;
      io_dout = d;
      io_we   = 1'b1;
      @(posedge clk);
      #1 io_we = 1'b0;
   endtask

   task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
      @(negedge clk);
      io_addr = a;
      io_rd   = 1'b1;
      #1 d = io_din;
      @(posedge clk);
      #1 io_rd = 1'b0;
   endtask

   task automatic peek(input logic [7:0] a, output logic [31:0] d);
      @(negedge clk);
      io_addr = a;
      #1 d = io_din;
   endtask

   task automatic pulse_in(input logic [31:0] d);
      @(negedge clk);
      in_data  = d;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic pulse_ack();
      @(negedge clk);
      out_ack = 1'b1;
      @(posedge clk);
      #1 out_ack = 1'b0;
   endtask

   initial begin
      logic [31:0] r;
      rstn = 1'b0; io_addr = '0; io_dout = '0; io_we = 1'b0; io_rd = 1'b0;
      in_data = '0; in_valid = 1'b0; out_ack = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk) rstn = 1'b1;

      // reset mid-run with pending output and held input
      bus_write(8'h00, 32'h0000_FFFF);
      bus_write(8'h10, 32'h0000_0077);
      pulse_in(32'h0000_00AA);
      check_eq("pre_reset_out_valid", 32'(out_valid), 32'd1);
      #2 rstn = 1'b0;
      #1;
      check_eq("rst_led", 32'(led), 32'd0);
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_out_data", out_data, 32'd0);
      peek(8'h04, r); check_eq("rst_in_status", r, 32'd0);
      peek(8'h0C, r); check_eq("rst_out_status", r, 32'd0);
      peek(8'h08, r); check_eq("rst_in_data", r, 32'd0);
      @(negedge clk);
      rstn    = 1'b1;
      io_addr = 8'h14;
      #1 check_eq("rst_cycle0", io_din, 32'd0);
      peek(8'h14, r); check_eq("rst_cycle1", r, 32'd1);

      // LED register and unmapped address
      bus_write(8'h00, 32'hDEAD_A5A5);
      check_eq("led_port", 32'(led), 32'h0000_A5A5);
      peek(8'h00, r); check_eq("led_read", r, 32'h0000_A5A5);
      bus_write(8'h3C, 32'h1234_5678);
      check_eq("led_unmapped_wr", 32'(led), 32'h0000_A5A5);
      peek(8'h3C, r); check_eq("unmapped_read", r, 32'd0);

`ifndef IO_IN_FIFO_EN
      // single holding register
      pulse_in(32'h1234_5678);
      peek(8'h04, r); check_eq("in_ready_set", r, 32'd1);
      bus_read(8'h08, r); check_eq("in_data_read", r, 32'h1234_5678);
      peek(8'h04, r); check_eq("in_ready_clr", r, 32'd0);
      peek(8'h08, r); check_eq("in_data_empty", r, 32'd0);
      pulse_in(32'h1);
      pulse_in(32'h2);
      peek(8'h04, r); check_eq("overrun_set", r, 32'd3);
      peek(8'h08, r); check_eq("overrun_keeps_old", r, 32'h1);
      bus_write(8'h04, 32'h2);
      peek(8'h04, r); check_eq("overrun_clr", r, 32'd1);
      // read and new data at the same edge
      @(negedge clk);
      io_addr = 8'h08; io_rd = 1'b1; in_data = 32'hB; in_valid = 1'b1;
      #1 check_eq("simul_rd_old", io_din, 32'h1);
      @(posedge clk);
      #1 begin io_rd = 1'b0; in_valid = 1'b0; end
      peek(8'h04, r); check_eq("simul_status", r, 32'd1);
      peek(8'h08, r); check_eq("simul_new_data", r, 32'hB);
      // overrun set wins over a clear at the same edge
      @(negedge clk);
      io_addr = 8'h04; io_dout = 32'h2; io_we = 1'b1; in_data = 32'hC; in_valid = 1'b1;
      @(posedge clk);
      #1 begin io_we = 1'b0; in_valid = 1'b0; end
      peek(8'h04, r); check_eq("overrun_set_wins", r, 32'd3);
      bus_read(8'h08, r); check_eq("drain", r, 32'hB);
      bus_write(8'h04, 32'h2);
`else
      // circular input FIFO
      for (int i = 1; i <= 5; i++) pulse_in(32'(i));
      peek(8'h04, r); check_eq("fifo_full_status", r, 32'h0000_0403);
      for (int i = 1; i <= 4; i++) begin
         bus_read(8'h08, r); check_eq("fifo_order", r, 32'(i));
      end
      peek(8'h04, r); check_eq("fifo_empty_status", r, 32'h0000_0002);
      bus_write(8'h04, 32'h2);
      for (int i = 10; i <= 13; i++) pulse_in(32'(i));
      @(negedge clk);
      io_addr = 8'h08; io_rd = 1'b1; in_data = 32'd14; in_valid = 1'b1;
      #1 check_eq("fifo_simul_pop", io_din, 32'd10);
      @(posedge clk);
      #1 begin io_rd = 1'b0; in_valid = 1'b0; end
      peek(8'h04, r); check_eq("fifo_simul_count", r, 32'h0000_0401);
      for (int i = 11; i <= 14; i++) begin
         bus_read(8'h08, r); check_eq("fifo_drain", r, 32'(i));
      end
`endif

      // output channel
      bus_write(8'h10, 32'h0000_0042);
      check_eq("out_valid_set", 32'(out_valid), 32'd1);
      check_eq("out_data", out_data, 32'h42);
      peek(8'h0C, r); check_eq("out_status_busy", r, 32'd1);
      bus_write(8'h10, 32'h0000_0099);
      check_eq("out_busy_ignored", out_data, 32'h42);
      pulse_ack();
      check_eq("out_valid_clr", 32'(out_valid), 32'd0);
      peek(8'h0C, r); check_eq("out_status_idle", r, 32'd0);
      pulse_ack();
      check_eq("ack_idle_ignored", 32'(out_valid), 32'd0);
      bus_write(8'h10, 32'h55);
      @(negedge clk);
      io_addr = 8'h10; io_dout = 32'h66; io_we = 1'b1; out_ack = 1'b1;
      @(posedge clk);
      #1 begin io_we = 1'b0; out_ack = 1'b0; end
      check_eq("ack_wr_state", 32'(out_valid), 32'd0);
      check_eq("ack_wr_dropped", out_data, 32'h55);

      // cycle counter clear and wrap
      bus_write(8'h14, 32'h0);
      io_addr = 8'h14;
      check_eq("cycle_clr", io_din, 32'd0);
      @(posedge clk);
      #1 check_eq("cycle_after_clr", io_din, 32'd1);
      @(negedge clk);
      force dut.cycle_q = 32'hFFFF_FFFE;
      #1 release dut.cycle_q;
      @(posedge clk);
      #1 check_eq("cycle_max", io_din, 32'hFFFF_FFFF);
      @(posedge clk);
      #1 check_eq("cycle_wrap", io_din, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
